// File: rtl/axi_bus_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi_bus_mem_pkg
// Shared definitions for the AXI4 memory slave:
//   - AXI response and burst encodings
//   - write/read engine state enums (also exported on the debug ports)
//   - stall LFSR seed and next-state helper (used when AXI_MEM_STALL_EN is set)
// ---------------------------------------------------------------------------
package axi_bus_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11 (bit 0 is the oldest stage, shift right).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/axi_bus_mem_slave_if.sv
// ---------------------------------------------------------------------------
// axi_bus_mem_slave_if
// AXI4 bus bundle between a master and the memory slave. Signal names keep
// the slave-side _i/_o suffixes so both ends refer to the same wires.
//   slave  modport: used by axi_bus_mem_slave
//   master modport: used by whatever drives the slave
//
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both high. A source holds valid and its
// payload stable until that edge; ready may be raised or dropped freely.
// ---------------------------------------------------------------------------
interface axi_bus_mem_slave_if #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 8,
  parameter int UserWidth = 1
);

  // write address
  logic [IdWidth-1:0]     aw_id_i;
  logic [AddrWidth-1:0]   aw_addr_i;
  logic [7:0]             aw_len_i;
  logic [2:0]             aw_size_i;
  logic [1:0]             aw_burst_i;
  logic [UserWidth-1:0]   aw_user_i;
  logic                   aw_valid_i;
  logic                   aw_ready_o;
  // write data
  logic [DataWidth-1:0]   w_data_i;
  logic [DataWidth/8-1:0] w_strb_i;
  logic                   w_last_i;
  logic [UserWidth-1:0]   w_user_i;
  logic                   w_valid_i;
  logic                   w_ready_o;
  // write response
  logic [IdWidth-1:0]     b_id_o;
  logic [1:0]             b_resp_o;
  logic [UserWidth-1:0]   b_user_o;
  logic                   b_valid_o;
  logic                   b_ready_i;
  // read address
  logic [IdWidth-1:0]     ar_id_i;
  logic [AddrWidth-1:0]   ar_addr_i;
  logic [7:0]             ar_len_i;
  logic [2:0]             ar_size_i;
  logic [1:0]             ar_burst_i;
  logic [UserWidth-1:0]   ar_user_i;
  logic                   ar_valid_i;
  logic                   ar_ready_o;
  // read data
  logic [IdWidth-1:0]     r_id_o;
  logic [DataWidth-1:0]   r_data_o;
  logic [1:0]             r_resp_o;
  logic                   r_last_o;
  logic [UserWidth-1:0]   r_user_o;
  logic                   r_valid_o;
  logic                   r_ready_i;

  modport slave (
    input  aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_user_i, aw_valid_i,
    output aw_ready_o,
    input  w_data_i, w_strb_i, w_last_i, w_user_i, w_valid_i,
    output w_ready_o,
    output b_id_o, b_resp_o, b_user_o, b_valid_o,
    input  b_ready_i,
    input  ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i, ar_valid_i,
    output ar_ready_o,
    output r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o, r_valid_o,
    input  r_ready_i
  );

  modport master (
    output aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_user_i, aw_valid_i,
    input  aw_ready_o,
    output w_data_i, w_strb_i, w_last_i, w_user_i, w_valid_i,
    input  w_ready_o,
    input  b_id_o, b_resp_o, b_user_o, b_valid_o,
    output b_ready_i,
    output ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_user_i, ar_valid_i,
    input  ar_ready_o,
    input  r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o, r_valid_o,
    output r_ready_i
  );

endinterface

// File: rtl/axi_bus_mem_array.sv
// ---------------------------------------------------------------------------
// axi_bus_mem_array
// MemWords x DataWidth storage, one byte-masked write port and one
// synchronous read port on the same clock. Contents are not reset.
// A read and a write to the same word in one cycle return the old word:
// both happen at the same edge and the read samples the pre-edge contents.
// Ports:
//   clk_i            clock
//   we_i/waddr_i     write enable / word index
//   wdata_i/wstrb_i  write data / per-byte enable
//   re_i/raddr_i     read enable / word index (rdata_o holds when re_i low)
//   rdata_o          registered read data
// ---------------------------------------------------------------------------
module axi_bus_mem_array #(
  parameter int DataWidth = 64,
  parameter int MemWords  = 1024,
  parameter int IdxWidth  = (MemWords > 1) ? $clog2(MemWords) : 1
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [IdxWidth-1:0]    waddr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  input  logic                   re_i,
  input  logic [IdxWidth-1:0]    raddr_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] mem [MemWords];
  logic [DataWidth-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DataWidth/8; b++) begin
        if (wstrb_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_bus_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_bus_mem_slave
// AXI4 slave backed by an internal word-addressed memory. Independent write
// and read engines, each serving one burst at a time. FIXED and INCR bursts
// (WRAP behaves as INCR), byte strobes, SLVERR for beats outside the memory.
// Optional build macro: AXI_MEM_STALL_EN -- a free-running LFSR randomly
// drops w_ready_o and r_valid_o to exercise master back-pressure handling.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   bus          AXI4 channels (axi_bus_mem_slave_if.slave)
//   w_state_dbg  write engine state
//   r_state_dbg  read engine state
// ---------------------------------------------------------------------------
module axi_bus_mem_slave
  import axi_bus_mem_pkg::*;
#(
  parameter int                   AddrWidth = 64,
  parameter int                   DataWidth = 64,
  parameter int                   IdWidth   = 8,
  parameter int                   UserWidth = 1,
  parameter int                   MemWords  = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  axi_bus_mem_slave_if.slave bus,
  output w_state_e           w_state_dbg,
  output r_state_e           r_state_dbg
);

  localparam int WordShift = $clog2(DataWidth/8);
  localparam int IdxWidth  = (MemWords > 1) ? $clog2(MemWords) : 1;

  // ---------------- address helpers ----------------
  function automatic logic addr_in_range(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] off;
    off = a - BaseAddr;
    return (a >= BaseAddr) && ((off >> WordShift) < AddrWidth'(MemWords));
  endfunction

  // Out-of-range beats never touch the array, so index 0 is a safe filler.
  function automatic logic [IdxWidth-1:0] addr_index(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] off;
    off = (a - BaseAddr) >> WordShift;
    return addr_in_range(a) ? IdxWidth'(off) : '0;
  endfunction

  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                     input logic [2:0]           size,
                                                     input logic [1:0]           burst);
    if (burst == BURST_FIXED) return a;
    return a + (AddrWidth'(1) << size);
  endfunction

  // ---------------- stall source ----------------
  logic stall;
`ifdef AXI_MEM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_next(lfsr_q);
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------- write engine ----------------
  w_state_e               w_state_q, w_state_d;
  logic                   aw_ready, w_ready, b_valid;
  logic                   aw_hs, w_hs, w_last_beat;
  logic [IdWidth-1:0]     w_id_q;
  logic [AddrWidth-1:0]   w_addr_q;
  logic [7:0]             w_len_q, w_cnt_q;
  logic [2:0]             w_size_q;
  logic [1:0]             w_burst_q;
  logic [UserWidth-1:0]   w_user_q;
  logic                   w_err_q;

  assign aw_hs       = aw_ready & bus.aw_valid_i;
  assign w_hs        = w_ready & bus.w_valid_i;
  assign w_last_beat = (w_cnt_q == w_len_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) w_state_q <= W_IDLE;
    else         w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (bus.aw_valid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready = ~stall;
        // beat count from len decides the end of the burst, not w_last_i
        if (bus.w_valid_i && !stall && w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (bus.b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_user_q  <= '0;
      w_err_q   <= 1'b0;
    end else if (aw_hs) begin
      w_id_q    <= bus.aw_id_i;
      w_addr_q  <= bus.aw_addr_i;
      w_len_q   <= bus.aw_len_i;
      w_cnt_q   <= '0;
      w_size_q  <= bus.aw_size_i;
      w_burst_q <= bus.aw_burst_i;
      w_user_q  <= bus.aw_user_i;
      w_err_q   <= 1'b0;
    end else if (w_hs) begin
      w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
      w_cnt_q  <= w_cnt_q + 8'd1;
      // sticky: one bad beat makes the whole burst SLVERR
      if (!addr_in_range(w_addr_q)) w_err_q <= 1'b1;
    end
  end

  assign bus.aw_ready_o = aw_ready;
  assign bus.w_ready_o  = w_ready;
  assign bus.b_valid_o  = b_valid;
  assign bus.b_id_o     = w_id_q;
  assign bus.b_user_o   = w_user_q;
  assign bus.b_resp_o   = w_err_q ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read engine ----------------
  r_state_e               r_state_q, r_state_d;
  logic                   ar_ready, r_valid;
  logic                   ar_hs, r_hs, r_last_beat;
  logic [IdWidth-1:0]     r_id_q;
  logic [AddrWidth-1:0]   r_addr_q, r_next_addr;
  logic [7:0]             r_len_q, r_cnt_q;
  logic [2:0]             r_size_q;
  logic [1:0]             r_burst_q;
  logic [UserWidth-1:0]   r_user_q;
  logic                   r_oor_q;

  assign ar_hs       = ar_ready & bus.ar_valid_i;
  assign r_hs        = r_valid & bus.r_ready_i;
  assign r_last_beat = (r_cnt_q == r_len_q);
  assign r_next_addr = next_addr(r_addr_q, r_size_q, r_burst_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state_q <= R_IDLE;
    else         r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (bus.ar_valid_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = ~stall;
        if (bus.r_ready_i && !stall && r_last_beat) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_user_q  <= '0;
      r_oor_q   <= 1'b0;
    end else if (ar_hs) begin
      r_id_q    <= bus.ar_id_i;
      r_addr_q  <= bus.ar_addr_i;
      r_len_q   <= bus.ar_len_i;
      r_cnt_q   <= '0;
      r_size_q  <= bus.ar_size_i;
      r_burst_q <= bus.ar_burst_i;
      r_user_q  <= bus.ar_user_i;
      r_oor_q   <= ~addr_in_range(bus.ar_addr_i);
    end else if (r_hs && !r_last_beat) begin
      r_addr_q <= r_next_addr;
      r_cnt_q  <= r_cnt_q + 8'd1;
      r_oor_q  <= ~addr_in_range(r_next_addr);
    end
  end

  // The array read register is the R data register: it loads the next beat
  // on the accepting edge and otherwise holds, so data is stable while the
  // master stalls.
  logic                 mem_re;
  logic [IdxWidth-1:0]  mem_raddr;
  logic [DataWidth-1:0] mem_rdata;

  assign mem_re    = ar_hs | (r_hs & ~r_last_beat);
  assign mem_raddr = ar_hs ? addr_index(bus.ar_addr_i) : addr_index(r_next_addr);

  axi_bus_mem_array #(
    .DataWidth (DataWidth),
    .MemWords  (MemWords),
    .IdxWidth  (IdxWidth)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_hs & addr_in_range(w_addr_q)),
    .waddr_i (addr_index(w_addr_q)),
    .wdata_i (bus.w_data_i),
    .wstrb_i (bus.w_strb_i),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign bus.ar_ready_o = ar_ready;
  assign bus.r_valid_o  = r_valid;
  assign bus.r_id_o     = r_id_q;
  assign bus.r_user_o   = r_user_q;
  assign bus.r_last_o   = (r_state_q == R_DATA) && r_last_beat;
  assign bus.r_resp_o   = r_oor_q ? RESP_SLVERR : RESP_OKAY;
  // zero outside a burst (array register is not reset) and for bad beats
  assign bus.r_data_o   = ((r_state_q == R_DATA) && !r_oor_q) ? mem_rdata : '0;

  assign w_state_dbg = w_state_q;
  assign r_state_dbg = r_state_q;

  // w_last_i and w_user_i carry nothing this slave needs
  logic unused_inputs;
  assign unused_inputs = ^{bus.w_last_i, bus.w_user_i};

endmodule

// File: tb/tb_axi_bus_mem_slave.sv
module tb_axi_bus_mem_slave;
  import axi_bus_mem_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 8;
  localparam int UW = 1;
  localparam int MW = 1024;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_bus_mem_slave_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW)) bus ();
  w_state_e w_state_dbg;
  r_state_e r_state_dbg;

  axi_bus_mem_slave #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .UserWidth(UW), .MemWords(MW), .BaseAddr('0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .w_state_dbg (w_state_dbg),
    .r_state_dbg (r_state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [1:0]    exp_resp_q[$];
  logic          exp_last_q[$];
  logic [DW-1:0] model_mem [MW];
  logic [DW-1:0] wbuf [16];
  logic [7:0]    sbuf [16];
  logic [DW-1:0] last_rdata;
  logic [1:0]    last_rresp;
  logic [1:0]    last_bresp;

  function automatic bit tb_in_range(input logic [AW-1:0] a);
    return a < AW'(MW * 8);
  endfunction

  function automatic logic [AW-1:0] tb_next(input logic [AW-1:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'd0) ? a : a + (64'd1 << size);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic init_inputs();
    bus.aw_id_i = '0; bus.aw_addr_i = '0; bus.aw_len_i = '0; bus.aw_size_i = '0;
    bus.aw_burst_i = '0; bus.aw_user_i = '0; bus.aw_valid_i = 1'b0;
    bus.w_data_i = '0; bus.w_strb_i = '0; bus.w_last_i = 1'b0; bus.w_user_i = '0;
    bus.w_valid_i = 1'b0; bus.b_ready_i = 1'b0;
    bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_len_i = '0; bus.ar_size_i = '0;
    bus.ar_burst_i = '0; bus.ar_user_i = '0; bus.ar_valid_i = 1'b0;
    bus.r_ready_i = 1'b0;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [UW-1:0] user);
    int n;
    bus.aw_id_i = id; bus.aw_addr_i = addr; bus.aw_len_i = len; bus.aw_size_i = size;
    bus.aw_burst_i = burst; bus.aw_user_i = user; bus.aw_valid_i = 1'b1;
    n = 0;
    while (bus.aw_ready_o !== 1'b1 && n < 50) begin wait_cycle(); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL aw_handshake: aw_ready=%b required 1 within 50 cycles", bus.aw_ready_o);
    end
    wait_cycle();
    bus.aw_valid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [UW-1:0] user);
    int n;
    bus.ar_id_i = id; bus.ar_addr_i = addr; bus.ar_len_i = len; bus.ar_size_i = size;
    bus.ar_burst_i = burst; bus.ar_user_i = user; bus.ar_valid_i = 1'b1;
    n = 0;
    while (bus.ar_ready_o !== 1'b1 && n < 50) begin wait_cycle(); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL ar_handshake: ar_ready=%b required 1 within 50 cycles", bus.ar_ready_o);
    end
    wait_cycle();
    bus.ar_valid_i = 1'b0;
  endtask

  // One W beat; updates the reference memory when the beat is accepted.
  task automatic w_beat(input logic [DW-1:0] data, input logic [7:0] strb, input logic last,
                        input logic [AW-1:0] a, output bit oor);
    int n;
    bus.w_data_i = data; bus.w_strb_i = strb; bus.w_last_i = last; bus.w_valid_i = 1'b1;
    n = 0;
    while (bus.w_ready_o !== 1'b1 && n < 50) begin wait_cycle(); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL w_handshake: w_ready=%b required 1 within 50 cycles", bus.w_ready_o);
    end
    wait_cycle();
    bus.w_valid_i = 1'b0;
    oor = !tb_in_range(a);
    if (!oor) begin
      for (int b = 0; b < DW/8; b++) begin
        if (strb[b]) model_mem[int'(a >> 3)][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [UW-1:0] user, input bit drive_last);
    logic [AW-1:0] a;
    bit oor, any_oor;
    logic [1:0] exp_resp;
    int n;
    send_aw(id, addr, len, 3'd3, burst, user);
    a = addr; any_oor = 0;
    for (int i = 0; i <= int'(len); i++) begin
      w_beat(wbuf[i], sbuf[i], drive_last && (i == int'(len)), a, oor);
      any_oor |= oor;
      a = tb_next(a, 3'd3, burst);
    end
    exp_resp = any_oor ? RESP_SLVERR : RESP_OKAY;
    checks++;
    if (bus.b_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b_latency: b_valid=%b required 1 one cycle after last W", bus.b_valid_o);
    end
    n = 0;
    while (bus.b_valid_o !== 1'b1 && n < 20) begin wait_cycle(); n++; end
    bus.b_ready_i = 1'b1;
    checks++;
    if (bus.b_resp_o !== exp_resp) begin
      errors++;
      $display("FAIL b_resp: got %0d required %0d", bus.b_resp_o, exp_resp);
    end
    checks++;
    if (bus.b_id_o !== id || bus.b_user_o !== user) begin
      errors++;
      $display("FAIL b_echo: id/user got %h/%h required %h/%h", bus.b_id_o, bus.b_user_o, id, user);
    end
    last_bresp = bus.b_resp_o;
    wait_cycle();
    bus.b_ready_i = 1'b0;
    checks++;
    if (bus.b_valid_o !== 1'b0 || bus.aw_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b_done: b_valid/aw_ready got %b/%b required 0/1", bus.b_valid_o, bus.aw_ready_o);
    end
  endtask

  task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [UW-1:0] user, input int hold);
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic [1:0]    er;
    logic          el;
    int n;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (tb_in_range(a)) begin
        exp_q.push_back(model_mem[int'(a >> 3)]);
        exp_resp_q.push_back(RESP_OKAY);
      end else begin
        exp_q.push_back('0);
        exp_resp_q.push_back(RESP_SLVERR);
      end
      exp_last_q.push_back(i == int'(len));
      a = tb_next(a, 3'd3, burst);
    end
    send_ar(id, addr, len, 3'd3, burst, user);
    checks++;
    if (bus.r_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL r_latency: r_valid=%b required 1 one cycle after AR", bus.r_valid_o);
    end
    for (int i = 0; i <= int'(len); i++) begin
      if (hold > 0) begin
        bus.r_ready_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
          wait_cycle();
          checks++;
          if (bus.r_valid_o !== 1'b1 || bus.r_data_o !== exp_q[0]) begin
            errors++;
            $display("FAIL r_hold: valid=%b data=%h required 1/%h", bus.r_valid_o, bus.r_data_o, exp_q[0]);
          end
        end
      end
      bus.r_ready_i = 1'b1;
      n = 0;
      while (bus.r_valid_o !== 1'b1 && n < 50) begin wait_cycle(); n++; end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL r_wait: r_valid=%b required 1 within 50 cycles", bus.r_valid_o);
      end
      ed = exp_q.pop_front();
      er = exp_resp_q.pop_front();
      el = exp_last_q.pop_front();
      checks++;
      if (bus.r_data_o !== ed) begin
        errors++;
        $display("FAIL r_data beat %0d: got %h required %h", i, bus.r_data_o, ed);
      end
      checks++;
      if (bus.r_resp_o !== er) begin
        errors++;
        $display("FAIL r_resp beat %0d: got %0d required %0d", i, bus.r_resp_o, er);
      end
      checks++;
      if (bus.r_last_o !== el) begin
        errors++;
        $display("FAIL r_last beat %0d: got %b required %b", i, bus.r_last_o, el);
      end
      checks++;
      if (bus.r_id_o !== id || bus.r_user_o !== user) begin
        errors++;
        $display("FAIL r_echo: id/user got %h/%h required %h/%h", bus.r_id_o, bus.r_user_o, id, user);
      end
      last_rdata = bus.r_data_o;
      last_rresp = bus.r_resp_o;
      wait_cycle();
    end
    bus.r_ready_i = 1'b0;
    checks++;
    if (bus.r_valid_o !== 1'b0 || bus.ar_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL r_done: r_valid/ar_ready got %b/%b required 0/1", bus.r_valid_o, bus.ar_ready_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.aw_ready_o !== 1'b1 || bus.ar_ready_o !== 1'b1 || bus.w_ready_o !== 1'b0 ||
        bus.b_valid_o !== 1'b0 || bus.r_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: aw_rdy/ar_rdy/w_rdy/b_vld/r_vld got %b%b%b%b%b required 11000",
               tag, bus.aw_ready_o, bus.ar_ready_o, bus.w_ready_o, bus.b_valid_o, bus.r_valid_o);
    end
    checks++;
    if (w_state_dbg !== W_IDLE || r_state_dbg !== R_IDLE) begin
      errors++;
      $display("FAIL %s state: w/r got %0d/%0d required 0/0", tag, w_state_dbg, r_state_dbg);
    end
  endtask

  task automatic test_reset();
    init_inputs();
    rst_ni = 1'b0;
    repeat (3) wait_cycle();
    check_reset_outputs("reset");
    checks++;
    if (bus.b_id_o !== '0 || bus.b_resp_o !== 2'd0 || bus.r_id_o !== '0 || bus.r_data_o !== '0 ||
        bus.r_resp_o !== 2'd0 || bus.r_last_o !== 1'b0) begin
      errors++;
      $display("FAIL reset payload: b_id=%h b_resp=%0d r_id=%h r_data=%h r_resp=%0d r_last=%b required all 0",
               bus.b_id_o, bus.b_resp_o, bus.r_id_o, bus.r_data_o, bus.r_resp_o, bus.r_last_o);
    end
    rst_ni = 1'b1;
    wait_cycle();
  endtask

  task automatic test_fixed_single();
    wbuf[0] = 64'hDEADBEEF_CAFEF00D; sbuf[0] = 8'hFF;
    write_burst(8'h5A, 64'h10, 8'd0, BURST_FIXED, 1'b1, 1'b1);
    read_burst(8'h3C, 64'h10, 8'd0, BURST_FIXED, 1'b0, 0);
    checks++;
    if (last_rdata !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL fixed_single: got %h required deadbeefcafef00d", last_rdata);
    end
  endtask

  task automatic test_incr_burst();
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; end
    write_burst(8'h21, 64'h0, 8'd3, BURST_INCR, 1'b0, 1'b1);
    read_burst(8'h22, 64'h0, 8'd3, BURST_INCR, 1'b1, 0);
    checks++;
    if (last_rdata !== 64'd4) begin
      errors++;
      $display("FAIL incr_burst last beat: got %h required 4", last_rdata);
    end
  endtask

  task automatic test_partial_strobe();
    wbuf[0] = '1; sbuf[0] = 8'hFF;
    write_burst(8'h31, 64'h40, 8'd0, BURST_INCR, 1'b0, 1'b1);
    wbuf[0] = 64'h11111111_22222222; sbuf[0] = 8'h0F;
    write_burst(8'h32, 64'h40, 8'd0, BURST_INCR, 1'b0, 1'b1);
    read_burst(8'h33, 64'h40, 8'd0, BURST_INCR, 1'b0, 0);
    checks++;
    if (last_rdata !== 64'hFFFFFFFF_22222222) begin
      errors++;
      $display("FAIL partial_strobe: got %h required ffffffff22222222", last_rdata);
    end
  endtask

  task automatic test_fixed_burst();
    wbuf[0] = 64'hA1; wbuf[1] = 64'hB2; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    write_burst(8'h41, 64'h80, 8'd1, BURST_FIXED, 1'b0, 1'b1);
    read_burst(8'h42, 64'h80, 8'd2, BURST_FIXED, 1'b0, 0);
    checks++;
    if (last_rdata !== 64'hB2) begin
      errors++;
      $display("FAIL fixed_burst: got %h required b2", last_rdata);
    end
  endtask

  task automatic test_w_early_and_last();
    bus.w_data_i = 64'hBAD0_BAD0; bus.w_strb_i = 8'hFF; bus.w_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      checks++;
      if (bus.w_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL w_early: w_ready got %b required 0 before AW", bus.w_ready_o);
      end
    end
    bus.w_valid_i = 1'b0;
    wbuf[0] = 64'h31; wbuf[1] = 64'h32; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    write_burst(8'h51, 64'h300, 8'd1, BURST_INCR, 1'b0, 1'b0);
    read_burst(8'h52, 64'h300, 8'd1, BURST_INCR, 1'b0, 0);
  endtask

  task automatic test_out_of_range();
    wbuf[0] = 64'h1234; sbuf[0] = 8'hFF;
    write_burst(8'h61, 64'(MW * 8), 8'd0, BURST_INCR, 1'b0, 1'b1);
    checks++;
    if (last_bresp !== RESP_SLVERR) begin
      errors++;
      $display("FAIL oor_write: b_resp got %0d required 2", last_bresp);
    end
    read_burst(8'h62, 64'(MW * 8), 8'd0, BURST_INCR, 1'b0, 0);
    checks++;
    if (last_rdata !== '0 || last_rresp !== RESP_SLVERR) begin
      errors++;
      $display("FAIL oor_read: data/resp got %h/%0d required 0/2", last_rdata, last_rresp);
    end
    // burst straddling the top of memory: first beat good, second dropped
    wbuf[0] = 64'h77; wbuf[1] = 64'h88; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    write_burst(8'h63, 64'(MW * 8 - 8), 8'd1, BURST_INCR, 1'b1, 1'b1);
    checks++;
    if (last_bresp !== RESP_SLVERR) begin
      errors++;
      $display("FAIL oor_straddle: b_resp got %0d required 2", last_bresp);
    end
    read_burst(8'h64, 64'(MW * 8 - 8), 8'd1, BURST_INCR, 1'b0, 0);
    // dropped beats must not have landed anywhere else
    read_burst(8'h65, 64'h0, 8'd0, BURST_INCR, 1'b0, 0);
    checks++;
    if (last_rdata !== 64'd1) begin
      errors++;
      $display("FAIL oor_untouched: word 0 got %h required 1", last_rdata);
    end
  endtask

  task automatic test_backpressure();
    read_burst(8'h71, 64'h0, 8'd1, BURST_INCR, 1'b1, 5);
  endtask

  task automatic test_reset_mid_burst();
    logic [AW-1:0] a;
    bit oor;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hAAAA_AAAA_AAAA_AAAA; sbuf[i] = 8'hFF; end
    write_burst(8'h81, 64'h200, 8'd3, BURST_INCR, 1'b0, 1'b1);
    send_aw(8'h82, 64'h200, 8'd3, 3'd3, BURST_INCR, 1'b1);
    a = 64'h200;
    for (int i = 0; i < 2; i++) begin
      w_beat(64'h5000 + 64'(i), 8'hFF, 1'b0, a, oor);
      a = a + 64'd8;
    end
    checks++;
    if (w_state_dbg !== W_DATA) begin
      errors++;
      $display("FAIL mid_burst state: got %0d required %0d", w_state_dbg, W_DATA);
    end
    bus.w_valid_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus.w_valid_i = 1'b0;
    repeat (2) wait_cycle();
    rst_ni = 1'b1;
    wait_cycle();
    read_burst(8'h83, 64'h200, 8'd3, BURST_INCR, 1'b0, 0);
    checks++;
    if (last_rdata !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      errors++;
      $display("FAIL mid_burst tail: got %h required aaaaaaaaaaaaaaaa", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] len;
    logic [AW-1:0] addr;
    for (int k = 0; k < 4; k++) begin
      len  = 8'($urandom_range(0, 7));
      addr = 64'($urandom_range(128, 900)) << 3;
      for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      write_burst(IW'($urandom_range(0, 255)), addr, len, BURST_INCR, UW'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 16; i++) begin
        wbuf[i] = {$urandom, $urandom};
        sbuf[i] = 8'($urandom_range(0, 255));
      end
      write_burst(IW'($urandom_range(0, 255)), addr, len, BURST_INCR, UW'($urandom_range(0, 1)), 1'b1);
      read_burst(IW'($urandom_range(0, 255)), addr, len, BURST_INCR, UW'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fixed_single();
    test_incr_burst();
    test_partial_strobe();
    test_fixed_burst();
    test_w_early_and_last();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_burst();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
